mem_burst_arbiter: RTL and testbench

Arbiter and sequencer that shares the single burst memory port behind the MMU between the instruction cache (line refill) and the data cache (line refill and line write-back). It grants one requester at a time, registers the line address, forwards the 16-beat burst to the winner, and returns to arbitration only after the final beat. Ties are broken round-robin between the two caches. Within the data cache, write-back beats refill.

---
 rtl/mem_burst_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// Shares one burst memory port between icache refills and dcache refill/write-back.
// One burst at a time; round-robin between caches on ties, write-back before refill in the dcache.
module mem_burst_arbiter #(
    parameter int BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       i_read_req,
    input  logic [31:0]                i_addr,
    output logic                       i_addr_ok,
    output logic [31:0]                i_read_data,
    output logic                       i_valid,
    output logic                       i_last,

    input  logic                       d_read_req,
    input  logic                       d_write_req,
    input  logic [31:0]                d_addr,
    output logic                       d_addr_ok,
    output logic [31:0]                d_read_data,
    output logic                       d_valid,
    output logic                       d_last,
    input  logic [31:0]                d_wdata,
    output logic [$clog2(BEATS)-1:0]   d_wbeat,
    output logic                       d_wdone,

    output logic [31:0]                mem_addr,
    output logic                       mem_read_req,
    output logic                       mem_write_req,
    input  logic                       mem_addr_ok,
    input  logic [31:0]                mem_read_data,
    input  logic                       mem_valid,
    input  logic                       mem_last,
    output logic [31:0]                mem_wdata,
    output logic                       mem_wvalid,
    input  logic                       mem_wready,
    output logic                       mem_wlast,
    output logic                       busy
);

    localparam int              CW        = $clog2(BEATS);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);
    localparam logic            OWN_I     = 1'b0;
    localparam logic            OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_is_write;
    logic           r_last_owner;
    logic [31:0]    r_mem_addr;
    logic [CW-1:0]  r_beat;

    logic w_i_cand;
    logic w_d_cand;
    logic w_grant_d;
    logic w_in_addr;
    logic w_in_rd;
    logic w_in_wr;
    logic w_rd_beat;
    logic w_i_rd;
    logic w_d_rd;
    logic w_wr_beat;
    logic w_beat_last;

    assign w_i_cand    = i_read_req;
    assign w_d_cand    = d_read_req | d_write_req;
    // D wins when alone, or on a tie when I owned the previous burst.
    assign w_grant_d   = w_d_cand & (~w_i_cand | (r_last_owner == OWN_I));

    assign w_in_addr   = (r_state == ADDR);
    assign w_in_rd     = (r_state == RDATA);
    assign w_in_wr     = (r_state == WDATA);
    assign w_beat_last = (r_beat == LAST_BEAT);

    assign w_rd_beat   = w_in_rd & mem_valid;
    assign w_i_rd      = w_rd_beat & (r_owner == OWN_I);
    assign w_d_rd      = w_rd_beat & (r_owner == OWN_D);
    assign w_wr_beat   = w_in_wr & mem_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_I;
            r_is_write   <= 1'b0;
            r_last_owner <= OWN_D;
            r_mem_addr   <= '0;
            r_beat       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_cand | w_d_cand) begin
                        r_state      <= ADDR;
                        r_owner      <= w_grant_d;
                        r_last_owner <= w_grant_d;
                        r_is_write   <= w_grant_d & d_write_req;
                        r_mem_addr   <= w_grant_d ? d_addr : i_addr;
                    end
                end
                ADDR: begin
                    if (mem_addr_ok) begin
                        r_beat  <= '0;
                        r_state <= r_is_write ? WDATA : RDATA;
                    end
                end
                RDATA: begin
                    // The counter may wrap; only mem_last ends a read burst.
                    if (mem_valid) begin
                        r_beat <= r_beat + CW'(1);
                        if (mem_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                WDATA: begin
                    if (mem_wready) begin
                        r_beat <= r_beat + CW'(1);
                        if (w_beat_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_addr_ok     = w_in_addr & mem_addr_ok & (r_owner == OWN_I);
    assign d_addr_ok     = w_in_addr & mem_addr_ok & (r_owner == OWN_D);

    assign i_valid       = w_i_rd;
    assign i_last        = w_i_rd & mem_last;
    assign i_read_data   = w_i_rd ? mem_read_data : '0;
    assign d_valid       = w_d_rd;
    assign d_last        = w_d_rd & mem_last;
    assign d_read_data   = w_d_rd ? mem_read_data : '0;

    assign d_wbeat       = w_in_wr ? r_beat : '0;
    assign d_wdone       = w_wr_beat & w_beat_last;

    assign mem_addr      = r_mem_addr;
    assign mem_read_req  = w_in_addr & ~r_is_write;
    assign mem_write_req = w_in_addr & r_is_write;
    assign mem_wvalid    = w_in_wr;
    assign mem_wdata     = w_in_wr ? d_wdata : '0;
    assign mem_wlast     = w_in_wr & w_beat_last;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: grant order, burst forwarding, write-back stepping,
// dropped beats, mid-burst reset and stalled address handshakes.
module tb_mem_burst_arbiter;

    localparam int BEATS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read_req, d_read_req, d_write_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_addr_ok, i_valid, i_last, d_addr_ok, d_valid, d_last, d_wdone;
    logic [31:0] i_read_data, d_read_data;
    logic [3:0]  d_wbeat;
    logic [31:0] mem_addr, mem_read_data, mem_wdata;
    logic        mem_read_req, mem_write_req, mem_addr_ok, mem_valid, mem_last;
    logic        mem_wvalid, mem_wready, mem_wlast, busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_burst_arbiter #(.BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_read_req(i_read_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_read_data(i_read_data), .i_valid(i_valid), .i_last(i_last),
        .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
        .d_addr_ok(d_addr_ok), .d_read_data(d_read_data), .d_valid(d_valid),
        .d_last(d_last), .d_wdata(d_wdata), .d_wbeat(d_wbeat), .d_wdone(d_wdone),
        .mem_addr(mem_addr), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr_ok(mem_addr_ok), .mem_read_data(mem_read_data), .mem_valid(mem_valid),
        .mem_last(mem_last), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_wlast(mem_wlast), .busy(busy)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_addr_ok   = 1'b0;
        mem_valid     = 1'b0;
        mem_last      = 1'b0;
        mem_read_data = '0;
        mem_wready    = 1'b0;
    endtask

    task automatic apply_reset();
        i_read_req  = 1'b0;
        d_read_req  = 1'b0;
        d_write_req = 1'b0;
        i_addr      = '0;
        d_addr      = '0;
        d_wdata     = '0;
        clear_mem();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
        #1;
    endtask

    // Drives n read beats starting in the current cycle; stays in the cycle of the final beat.
    task automatic drive_read(input int n, output int vi, output int vd, output int vl);
        vi = 0;
        vd = 0;
        vl = 0;
        for (int b = 0; b < n; b++) begin
            if (b > 0) nxt();
            mem_valid     = 1'b1;
            mem_read_data = 32'hA500_0000 + 32'(b);
            mem_last      = (b == BEATS - 1);
            #1;
            vi = vi + (i_valid ? 1 : 0);
            vd = vd + (d_valid ? 1 : 0);
            vl = vl + ((i_last | d_last) ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({i_addr_ok, i_valid, i_last, d_addr_ok, d_valid, d_last, d_wdone, mem_read_req,
             mem_write_req, mem_wvalid, mem_wlast, busy} !== 12'h000 || i_read_data !== 32'h0 ||
            d_read_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || d_wbeat !== 4'h0) begin
            n_err++;
            $display("FAIL reset_outs: busy=%b mem_addr=%h d_wbeat=%h, required all zero", busy, mem_addr, d_wbeat);
        end
    endtask

    task automatic test_lone_icache();
        apply_reset();
        nxt(); i_read_req = 1'b1; i_addr = 32'h1FC0_0040; #1;
        n_vec++;
        if (mem_read_req !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL lone_c0: mem_read_req=%b busy=%b, required 0 0", mem_read_req, busy);
        end
        nxt(); #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_addr !== 32'h1FC0_0040 || i_addr_ok !== 1'b0) begin
            n_err++; $display("FAIL lone_c1: req=%b addr=%h ok=%b, required 1 1fc00040 0", mem_read_req, mem_addr, i_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0 || mem_addr !== 32'h1FC0_0040) begin
            n_err++; $display("FAIL lone_c2: i_ok=%b d_ok=%b addr=%h, required 1 0 1fc00040", i_addr_ok, d_addr_ok, mem_addr);
        end
        nxt(); mem_addr_ok = 1'b0; i_read_req = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (b > 0) nxt();
            mem_valid = 1'b1; mem_read_data = 32'(b); mem_last = (b == BEATS - 1); #1;
            n_vec++;
            if (i_valid !== 1'b1 || i_read_data !== 32'(b) || i_last !== (b == BEATS - 1) ||
                d_valid !== 1'b0 || i_addr_ok !== 1'b0) begin
                n_err++;
                $display("FAIL lone_beat%0d: v=%b data=%h last=%b d_valid=%b, required 1 %h %b 0",
                         b, i_valid, i_read_data, i_last, d_valid, b, (b == BEATS - 1));
            end
        end
        nxt(); clear_mem(); #1;
        n_vec++;
        if (busy !== 1'b0 || i_valid !== 1'b0) begin
            n_err++; $display("FAIL lone_end: busy=%b i_valid=%b, required 0 0", busy, i_valid);
        end
        nxt(); #1;
        n_vec++;
        if (mem_read_req !== 1'b0) begin
            n_err++; $display("FAIL lone_no_regrant: mem_read_req=%b, required 0", mem_read_req);
        end
    endtask

    task automatic test_tie_alternation();
        int vi, vd, vl;
        apply_reset();
        nxt();
        i_read_req = 1'b1; d_read_req = 1'b1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; #1;
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (mem_addr !== 32'h0000_1000 || i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0) begin
            n_err++; $display("FAIL tie1_grant: addr=%h i_ok=%b d_ok=%b, required 00001000 1 0", mem_addr, i_addr_ok, d_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b0; i_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vi != BEATS || vd != 0 || vl != 1) begin
            n_err++; $display("FAIL tie1_burst: i=%0d d=%0d last=%0d, required 16 0 1", vi, vd, vl);
        end
        nxt(); clear_mem(); #1;
        n_vec++;
        if (busy !== 1'b0 || mem_read_req !== 1'b0 || d_addr_ok !== 1'b0) begin
            n_err++; $display("FAIL tie_dead_cycle: busy=%b req=%b d_ok=%b, required 0 0 0", busy, mem_read_req, d_addr_ok);
        end
        nxt(); #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_addr !== 32'h0000_2000 || d_addr_ok !== 1'b0) begin
            n_err++; $display("FAIL tie2_grant: req=%b addr=%h d_ok=%b, required 1 00002000 0", mem_read_req, mem_addr, d_addr_ok);
        end
        mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            n_err++; $display("FAIL tie2_addr_ok: d_ok=%b i_ok=%b, required 1 0", d_addr_ok, i_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b0; d_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vi != 0 || vd != BEATS || vl != 1) begin
            n_err++; $display("FAIL tie2_burst: i=%0d d=%0d last=%0d, required 0 16 1", vi, vd, vl);
        end
        nxt(); clear_mem();
        i_read_req = 1'b1; d_read_req = 1'b1; i_addr = 32'h0000_3000; d_addr = 32'h0000_4000; #1;
        nxt(); #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
            n_err++; $display("FAIL tie3_grant: req=%b addr=%h, required 1 00003000", mem_read_req, mem_addr);
        end
    endtask

    task automatic test_dcache_writeback();
        int vi, vd, vl, k, t;
        logic rdy;
        apply_reset();
        nxt(); d_write_req = 1'b1; d_read_req = 1'b1; d_addr = 32'h8000_0100; #1;
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (mem_write_req !== 1'b1 || mem_read_req !== 1'b0 || mem_addr !== 32'h8000_0100 || d_addr_ok !== 1'b1) begin
            n_err++; $display("FAIL wb_grant: wreq=%b rreq=%b addr=%h ok=%b, required 1 0 80000100 1",
                              mem_write_req, mem_read_req, mem_addr, d_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b0; d_write_req = 1'b0; d_addr = 32'h8000_0200;
        k = 0;
        t = 0;
        while (k < BEATS && t < 64) begin
            if (t > 0) nxt();
            rdy = (t % 2 == 0);
            mem_wready = rdy;
            d_wdata = 32'hDA7A_0000 + 32'(k);
            #1;
            n_vec++;
            if (mem_wvalid !== 1'b1 || d_wbeat !== 4'(k) || mem_wdata !== 32'hDA7A_0000 + 32'(k) ||
                mem_wlast !== (k == BEATS - 1) || d_wdone !== (rdy && k == BEATS - 1) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL wb_beat_t%0d: wvalid=%b wbeat=%0d wdata=%h wlast=%b wdone=%b, required 1 %0d %h %b %b",
                         t, mem_wvalid, d_wbeat, mem_wdata, mem_wlast, d_wdone, k,
                         32'hDA7A_0000 + 32'(k), (k == BEATS - 1), (rdy && k == BEATS - 1));
            end
            if (rdy) k++;
            t++;
        end
        nxt(); mem_wready = 1'b0; #1;
        n_vec++;
        if (busy !== 1'b0 || mem_wvalid !== 1'b0 || d_wdone !== 1'b0 || d_wbeat !== 4'h0) begin
            n_err++; $display("FAIL wb_end: busy=%b wvalid=%b wdone=%b, required 0 0 0", busy, mem_wvalid, d_wdone);
        end
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_write_req !== 1'b0 || mem_addr !== 32'h8000_0200 || d_addr_ok !== 1'b1) begin
            n_err++; $display("FAIL wb_then_read: rreq=%b wreq=%b addr=%h ok=%b, required 1 0 80000200 1",
                              mem_read_req, mem_write_req, mem_addr, d_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b0; d_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vd != BEATS || vi != 0 || vl != 1) begin
            n_err++; $display("FAIL wb_read_burst: d=%0d i=%0d last=%0d, required 16 0 1", vd, vi, vl);
        end
        nxt(); clear_mem(); #1;
    endtask

    task automatic test_spurious_valid();
        int vi, vd, vl;
        apply_reset();
        nxt(); mem_valid = 1'b1; mem_last = 1'b1; mem_read_data = 32'hDEAD_BEEF; #1;
        n_vec++;
        if ({i_valid, d_valid, i_last, d_last} !== 4'h0 || i_read_data !== 32'h0 || d_read_data !== 32'h0) begin
            n_err++; $display("FAIL spur_idle: iv=%b dv=%b idata=%h, required 0 0 0", i_valid, d_valid, i_read_data);
        end
        nxt(); i_read_req = 1'b1; i_addr = 32'h0000_5000; #1;
        nxt(); #1;
        n_vec++;
        if ({i_valid, d_valid, i_last, d_last} !== 4'h0 || busy !== 1'b1 || mem_read_req !== 1'b1) begin
            n_err++; $display("FAIL spur_addr: iv=%b dv=%b busy=%b req=%b, required 0 0 1 1", i_valid, d_valid, busy, mem_read_req);
        end
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (i_addr_ok !== 1'b1 || i_valid !== 1'b0 || i_last !== 1'b0) begin
            n_err++; $display("FAIL spur_addr_ok: ok=%b iv=%b il=%b, required 1 0 0", i_addr_ok, i_valid, i_last);
        end
        nxt(); mem_addr_ok = 1'b0; i_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vi != BEATS || vd != 0 || vl != 1) begin
            n_err++; $display("FAIL spur_burst: i=%0d d=%0d last=%0d, required 16 0 1", vi, vd, vl);
        end
        nxt(); clear_mem(); #1;
    endtask

    task automatic test_reset_mid_burst();
        int vi, vd, vl;
        apply_reset();
        nxt(); i_read_req = 1'b1; i_addr = 32'h0000_6000; #1;
        nxt(); mem_addr_ok = 1'b1; #1;
        nxt(); mem_addr_ok = 1'b0; i_read_req = 1'b0;
        drive_read(8, vi, vd, vl);
        rst = 1'b1; #1;
        n_vec++;
        if (vi != 8 || i_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_pre: beats=%0d iv=%b, required 8 1", vi, i_valid);
        end
        nxt(); rst = 1'b0; mem_valid = 1'b1; mem_last = 1'b0; mem_read_data = 32'h0000_0055; #1;
        n_vec++;
        if ({i_addr_ok, i_valid, i_last, d_addr_ok, d_valid, d_last, d_wdone, mem_read_req,
             mem_write_req, mem_wvalid, mem_wlast, busy} !== 12'h000 || i_read_data !== 32'h0 || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_outs: busy=%b iv=%b idata=%h addr=%h, required 0 0 0 0",
                              busy, i_valid, i_read_data, mem_addr);
        end
        nxt(); d_read_req = 1'b1; d_addr = 32'h0000_7000; #1;
        n_vec++;
        if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_drop: iv=%b dv=%b, required 0 0", i_valid, d_valid);
        end
        nxt(); mem_valid = 1'b0; mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_addr !== 32'h0000_7000 || d_addr_ok !== 1'b1) begin
            n_err++; $display("FAIL rst_dgrant: req=%b addr=%h ok=%b, required 1 00007000 1", mem_read_req, mem_addr, d_addr_ok);
        end
        nxt(); mem_addr_ok = 1'b0; d_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vd != BEATS || vi != 0) begin
            n_err++; $display("FAIL rst_dburst: d=%0d i=%0d, required 16 0", vd, vi);
        end
        nxt(); clear_mem(); #1;
    endtask

    task automatic test_addr_ok_delay();
        int vi, vd, vl;
        apply_reset();
        nxt(); d_read_req = 1'b1; d_addr = 32'h8000_0C40; #1;
        nxt(); i_read_req = 1'b1; i_addr = 32'h1FC0_0080; #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                nxt();
                #1;
            end
            n_vec++;
            if (mem_read_req !== 1'b1 || mem_addr !== 32'h8000_0C40 || i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0) begin
                n_err++; $display("FAIL stall_c%0d: req=%b addr=%h i_ok=%b d_ok=%b, required 1 80000c40 0 0",
                                  c, mem_read_req, mem_addr, i_addr_ok, d_addr_ok);
            end
        end
        nxt(); mem_addr_ok = 1'b1; #1;
        n_vec++;
        if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0 || mem_addr !== 32'h8000_0C40) begin
            n_err++; $display("FAIL stall_ok: d_ok=%b i_ok=%b addr=%h, required 1 0 80000c40", d_addr_ok, i_addr_ok, mem_addr);
        end
        nxt(); mem_addr_ok = 1'b0; d_read_req = 1'b0;
        drive_read(BEATS, vi, vd, vl);
        n_vec++;
        if (vd != BEATS || vi != 0 || vl != 1) begin
            n_err++; $display("FAIL stall_burst: d=%0d i=%0d last=%0d, required 16 0 1", vd, vi, vl);
        end
        nxt(); clear_mem(); #1;
        nxt(); #1;
        n_vec++;
        if (mem_read_req !== 1'b1 || mem_addr !== 32'h1FC0_0080) begin
            n_err++; $display("FAIL stall_next_grant: req=%b addr=%h, required 1 1fc00080", mem_read_req, mem_addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_lone_icache();
        test_tie_alternation();
        test_dcache_writeback();
        test_spurious_valid();
        test_reset_mid_burst();
        test_addr_ok_delay();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
